// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, prefix-decoder state encoding and the key event record
// used by the decoder and its event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } prefix_state_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Key event FIFO: push/full on the write side, valid/ready on the read side.
// A push that finds the FIFO full with no same-cycle pop is dropped and flagged.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  key_evt_t push_data,
    output logic     full,
    output logic     out_valid,
    input  logic     out_ready,
    output key_evt_t out_data,
    output logic     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    key_evt_t    mem [DEPTH];
    logic        empty;
    logic        pop;
    logic        wr_en;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_INC;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_INC;
            end
            overflow <= push & full & ~pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events, queues them in
// a small FIFO and tracks the held state of the left/right arrow keys.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code_data,
    input  logic       code_error,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       left_held,
    output logic       right_held,
    output logic       overflow
);

    prefix_state_t state;
    key_evt_t      evt_new;
    key_evt_t      head;
    logic          evt_done;
    logic          fifo_full;

    always_comb begin
        evt_new      = '0;
        evt_new.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
        evt_new.brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
        evt_new.code = code_data;
        evt_done     = code_valid & ~code_error & ~is_prefix(code_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            left_held  <= 1'b0;
            right_held <= 1'b0;
        end else if (code_valid) begin
            if (code_error) begin
                state <= ST_IDLE;
            end else if (code_data == PS2_EXT) begin
                state <= ST_EXT;
            end else if (code_data == PS2_BRK) begin
                case (state)
                    ST_IDLE: state <= ST_BRK;
                    ST_EXT:  state <= ST_EXT_BRK;
                    default: state <= state;
                endcase
            end else begin
                state <= ST_IDLE;
                if (code_data == KEY_LEFT) begin
                    left_held <= ~evt_new.brk;
                end
                if (code_data == KEY_RIGHT) begin
                    right_held <= ~evt_new.brk;
                end
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (evt_done),
        .push_data(evt_new),
        .full     (fifo_full),
        .out_valid(evt_valid),
        .out_ready(evt_ready),
        .out_data (head),
        .overflow (overflow)
    );

    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table-driven prefix decoding plus
// hand-written FIFO overflow, full-with-pop and mid-sequence reset sequences.
module tb_ps2_key_decoder;

    logic       clk;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] code_data;
    logic       code_error;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       left_held;
    logic       right_held;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int ovf_seen = 0;

    ps2_key_decoder #(
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_valid(code_valid),
        .code_data (code_data),
        .code_error(code_error),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .left_held (left_held),
        .right_held(right_held),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && overflow) ovf_seen = ovf_seen + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       v;
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic       left;
        logic       right;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with the strobe cleared.
    task automatic send(input logic [7:0] b, input logic e);
        code_valid = 1'b1;
        code_data  = b;
        code_error = e;
        @(negedge clk);
        code_valid = 1'b0;
        code_error = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " evt_valid"}, 32'(evt_valid), 0);
        check({tag, " evt_code"}, 32'(evt_code), 0);
        check({tag, " evt_ext"}, 32'(evt_ext), 0);
        check({tag, " evt_break"}, 32'(evt_break), 0);
        check({tag, " left_held"}, 32'(left_held), 0);
        check({tag, " right_held"}, 32'(right_held), 0);
        check({tag, " overflow"}, 32'(overflow), 0);
    endtask

    logic [7:0] exp_order [4];
    int base;

    initial begin
        //            data   err   v     ext   brk   code   left  right
        vecs[0]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B, 1'b1, 1'b0};
        vecs[2]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b0};
        vecs[5]  = '{8'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'h74, 1'b0, 1'b1, 1'b0, 1'b0, 8'h74, 1'b0, 1'b1};
        vecs[7]  = '{8'h6B, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B, 1'b1, 1'b1};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b1};
        vecs[9]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{8'h74, 1'b0, 1'b1, 1'b0, 1'b1, 8'h74, 1'b1, 1'b0};
        vecs[12] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0, 8'h6B, 1'b1, 1'b0};
        vecs[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[16] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[18] = '{8'h74, 1'b0, 1'b1, 1'b1, 1'b0, 8'h74, 1'b1, 1'b1};
        vecs[19] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[20] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[21] = '{8'h6B, 1'b0, 1'b1, 1'b0, 1'b0, 8'h6B, 1'b1, 1'b1};
        vecs[22] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[23] = '{8'h6B, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[24] = '{8'h74, 1'b0, 1'b1, 1'b0, 1'b0, 8'h74, 1'b1, 1'b1};

        rst_n      = 1'b0;
        code_valid = 1'b0;
        code_data  = 8'h00;
        code_error = 1'b0;
        evt_ready  = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table: ready held high, so each completed event is visible for exactly one cycle.
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].data, vecs[i].err);
            check($sformatf("vec%0d evt_valid", i), 32'(evt_valid), 32'(vecs[i].v));
            if (vecs[i].v) begin
                check($sformatf("vec%0d evt_code", i), 32'(evt_code), 32'(vecs[i].code));
                check($sformatf("vec%0d evt_ext", i), 32'(evt_ext), 32'(vecs[i].ext));
                check($sformatf("vec%0d evt_break", i), 32'(evt_break), 32'(vecs[i].brk));
            end
            check($sformatf("vec%0d left_held", i), 32'(left_held), 32'(vecs[i].left));
            check($sformatf("vec%0d right_held", i), 32'(right_held), 32'(vecs[i].right));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 0);
        end
        @(negedge clk);
        check("table drained", 32'(evt_valid), 0);

        // Overflow: six makes into a depth-4 FIFO with the consumer stalled.
        evt_ready = 1'b0;
        base = ovf_seen;
        for (int k = 0; k < 6; k++) send(8'h1C + 8'(k), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("ovf pulse count", 32'(ovf_seen - base), 2);
        check("ovf low after pulses", 32'(overflow), 0);
        check("ovf head stable valid", 32'(evt_valid), 1);
        check("ovf head stable code", 32'(evt_code), 32'h1C);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf drain%0d valid", k), 32'(evt_valid), 1);
            check($sformatf("ovf drain%0d code", k), 32'(evt_code), 32'h1C + 32'(k));
            @(negedge clk);
        end
        check("ovf drained", 32'(evt_valid), 0);
        check("ovf held flags", 32'({left_held, right_held}), 32'b11);

        // Full FIFO with a pop and a push in the same cycle.
        evt_ready = 1'b0;
        base = ovf_seen;
        send(8'h15, 1'b0);
        send(8'h16, 1'b0);
        send(8'h1A, 1'b0);
        send(8'h22, 1'b0);
        @(negedge clk);
        check("full head code", 32'(evt_code), 32'h15);
        evt_ready = 1'b1;
        send(8'h29, 1'b0);
        exp_order[0] = 8'h16;
        exp_order[1] = 8'h1A;
        exp_order[2] = 8'h22;
        exp_order[3] = 8'h29;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fullpop drain%0d valid", k), 32'(evt_valid), 1);
            check($sformatf("fullpop drain%0d code", k), 32'(evt_code), 32'(exp_order[k]));
            @(negedge clk);
        end
        check("fullpop drained", 32'(evt_valid), 0);
        @(negedge clk);
        check("fullpop no overflow", 32'(ovf_seen - base), 0);

        // Reset after an E0 prefix with state pending everywhere.
        evt_ready = 1'b0;
        send(8'h6B, 1'b0);
        send(8'hE0, 1'b0);
        check("pre-reset valid", 32'(evt_valid), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("held reset");
        rst_n = 1'b1;
        evt_ready = 1'b1;
        @(negedge clk);
        send(8'h6B, 1'b0);
        check("post-reset valid", 32'(evt_valid), 1);
        check("post-reset code", 32'(evt_code), 32'h6B);
        check("post-reset ext", 32'(evt_ext), 0);
        check("post-reset break", 32'(evt_break), 0);
        check("post-reset left", 32'(left_held), 1);
        check("post-reset right", 32'(right_held), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
